// File: rtl/network_descriptor_arbiter.sv
// N-channel descriptor arbiter: grants wr/ack sources in round-robin or strict
// priority order into a small FIFO that drains into registered outputs under backpressure.
module network_descriptor_arbiter #(
  parameter int CH_NUM     = 4,
  parameter int CH_W       = 2,
  parameter int TAG_W      = 48,
  parameter int BUFID_W    = 9,
  parameter int TYPE_W     = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CH_NUM*TAG_W-1:0]   iv_tsntag,
  input  logic [CH_NUM*TYPE_W-1:0]  iv_pkt_type,
  input  logic [CH_NUM*BUFID_W-1:0] iv_bufid,
  input  logic [CH_NUM-1:0]         iv_descriptor_wr,
  output logic [CH_NUM-1:0]         ov_descriptor_ack,
  input  logic [CH_NUM-1:0]         iv_ch_enable,
  input  logic                      i_arb_mode,
  output logic [TAG_W+BUFID_W-1:0]  ov_fifo_wdata,
  output logic [TYPE_W-1:0]         ov_pkt_type,
  output logic [CH_W-1:0]           ov_src_ch,
  output logic                      o_fifo_wr,
  input  logic                      i_fifo_ready,
  output logic [AW:0]               ov_fifo_usedw,
  output logic [15:0]               ov_accept_cnt
);
  localparam int          ENT_W    = TAG_W + BUFID_W + TYPE_W + CH_W;
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  logic [CH_NUM-1:0]        ack_q, ack_d;
  logic [CH_W-1:0]          last_grant_q, last_grant_d;
  logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]              usedw_q, usedw_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     out_wr_q, out_wr_d;
  logic [TAG_W+BUFID_W-1:0] out_data_q, out_data_d;
  logic [TYPE_W-1:0]        out_type_q, out_type_d;
  logic [CH_W-1:0]          out_src_q, out_src_d;

  logic [TAG_W-1:0]   tag_ch   [CH_NUM];
  logic [BUFID_W-1:0] bufid_ch [CH_NUM];
  logic [TYPE_W-1:0]  type_ch  [CH_NUM];
  logic [CH_NUM-1:0]  elig;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] wr_entry, rd_entry;
  logic [CH_W-1:0]  grant, idx;
  logic             found, capture, pop;

  // A channel is masked during its own ack cycle so a stale wr is never re-granted.
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign tag_ch[gi]   = iv_tsntag[gi*TAG_W +: TAG_W];
      assign bufid_ch[gi] = iv_bufid[gi*BUFID_W +: BUFID_W];
      assign type_ch[gi]  = iv_pkt_type[gi*TYPE_W +: TYPE_W];
      assign elig[gi]     = iv_descriptor_wr[gi] & iv_ch_enable[gi] & ~ack_q[gi];
    end
  endgenerate

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (i_arb_mode) idx = CH_W'(i);
      else            idx = CH_W'((int'(last_grant_q) + 1 + i) % CH_NUM);
      if (!found && elig[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Fullness is judged before any same-cycle pop, so a full FIFO never captures.
  assign capture  = found && (usedw_q != FULL_LVL);
  assign pop      = (usedw_q != '0) && i_fifo_ready;
  assign wr_entry = {tag_ch[grant], bufid_ch[grant], type_ch[grant], grant};
  assign rd_entry = mem[rptr_q];

  always_comb begin
    ack_d        = '0;
    last_grant_d = last_grant_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    usedw_d      = usedw_q;
    cnt_d        = cnt_q;
    out_wr_d     = pop;
    out_data_d   = out_data_q;
    out_type_d   = out_type_q;
    out_src_d    = out_src_q;
    if (capture) begin
      ack_d[grant] = 1'b1;
      last_grant_d = grant;
      wptr_d       = wptr_q + AW'(1);
      cnt_d        = cnt_q + 16'd1;
    end
    if (pop) begin
      rptr_d     = rptr_q + AW'(1);
      out_data_d = rd_entry[ENT_W-1 -: TAG_W+BUFID_W];
      out_type_d = rd_entry[CH_W +: TYPE_W];
      out_src_d  = rd_entry[CH_W-1:0];
    end
    if (capture && !pop)      usedw_d = usedw_q + (AW+1)'(1);
    else if (!capture && pop) usedw_d = usedw_q - (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (capture) mem[wptr_q] <= wr_entry;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ack_q        <= '0;
      last_grant_q <= CH_W'(CH_NUM - 1);
      wptr_q       <= '0;
      rptr_q       <= '0;
      usedw_q      <= '0;
      cnt_q        <= '0;
      out_wr_q     <= 1'b0;
      out_data_q   <= '0;
      out_type_q   <= '0;
      out_src_q    <= '0;
    end else begin
      ack_q        <= ack_d;
      last_grant_q <= last_grant_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      usedw_q      <= usedw_d;
      cnt_q        <= cnt_d;
      out_wr_q     <= out_wr_d;
      out_data_q   <= out_data_d;
      out_type_q   <= out_type_d;
      out_src_q    <= out_src_d;
    end
  end

  assign ov_descriptor_ack = ack_q;
  assign ov_fifo_wdata     = out_data_q;
  assign ov_pkt_type       = out_type_q;
  assign ov_src_ch         = out_src_q;
  assign o_fifo_wr         = out_wr_q;
  assign ov_fifo_usedw     = usedw_q;
  assign ov_accept_cnt     = cnt_q;
endmodule

// File: tb/tb_network_descriptor_arbiter.sv
// Scoreboard bench for network_descriptor_arbiter: directed source queues per channel,
// expected outputs queued in hand-derived grant order, checked by an independent monitor.
module tb_network_descriptor_arbiter;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH*48-1:0]  tsntag = '0;
  logic [CH*3-1:0]   pkt_type = '0;
  logic [CH*9-1:0]   bufid = '0;
  logic [CH-1:0]     wr = '0;
  logic [CH-1:0]     ack;
  logic [CH-1:0]     en = '1;
  logic              mode = 1'b0;
  logic [56:0]       wdata;
  logic [2:0]        otype;
  logic [1:0]        osrc;
  logic              owr;
  logic              ready = 1'b1;
  logic [3:0]        usedw;
  logic [15:0]       cnt;

  always #5 clk = ~clk;

  network_descriptor_arbiter dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .iv_tsntag         (tsntag),
    .iv_pkt_type       (pkt_type),
    .iv_bufid          (bufid),
    .iv_descriptor_wr  (wr),
    .ov_descriptor_ack (ack),
    .iv_ch_enable      (en),
    .i_arb_mode        (mode),
    .ov_fifo_wdata     (wdata),
    .ov_pkt_type       (otype),
    .ov_src_ch         (osrc),
    .o_fifo_wr         (owr),
    .i_fifo_ready      (ready),
    .ov_fifo_usedw     (usedw),
    .ov_accept_cnt     (cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [61:0] sb[$];
  logic [59:0] src_mem [CH][16];
  int          src_cnt [CH] = '{default: 0};
  int          src_idx [CH] = '{default: 0};
  logic        raw_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [59:0] mk(input int ch, input int n);
    logic [47:0] t;
    logic [8:0]  b;
    logic [2:0]  ty;
    t  = 48'((ch + 1) * 32'h0010_0000 + n);
    b  = 9'(ch * 32 + n);
    ty = 3'(ch + n);
    return {t, b, ty};
  endfunction

  task automatic load(input int ch, input logic [59:0] d);
    src_mem[ch][src_cnt[ch]] = d;
    src_cnt[ch]++;
  endtask

  task automatic expect_out(input int ch, input logic [59:0] d);
    sb.push_back({d, 2'(ch)});
  endtask

  task automatic clear_sources();
    for (int k = 0; k < CH; k++) begin
      src_cnt[k] = 0;
      src_idx[k] = 0;
    end
  endtask

  // Called at a falling edge; returns at a falling edge with reset just released.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_sources();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((sb.size() != 0 || usedw != 0 || owr) && i < 300) begin
      @(negedge clk);
      i++;
    end
    check({name, "_drained"}, 64'(i < 300), 64'd1);
  endtask

  // Source model: advance on ack, present the next queued descriptor (or drop wr).
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < CH; k++) begin
      if (raw_mode) begin
        wr[k] = 1'b1;
      end else begin
        if (ack[k] && src_idx[k] < src_cnt[k]) src_idx[k]++;
        if (src_idx[k] < src_cnt[k]) begin
          wr[k] = 1'b1;
          {tsntag[k*48 +: 48], bufid[k*9 +: 9], pkt_type[k*3 +: 3]} = src_mem[k][src_idx[k]];
        end else begin
          wr[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && owr && !raw_mode) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got 0x%0h expected none", {wdata, otype, osrc});
      end else begin
        logic [61:0] e;
        e = sb.pop_front();
        check("out_desc", {2'b00, wdata, otype, osrc}, {2'b00, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int i;
    logic [59:0] d;
    @(negedge clk);

    // Single descriptor, reset state
    do_reset();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_wr", 64'(owr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_type", 64'(otype), 64'd0);
    check("rst_src", 64'(osrc), 64'd0);
    check("rst_usedw", 64'(usedw), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    d = {48'h0000_0000_1234, 9'h005, 3'd3};
    load(0, d);
    expect_out(0, d);
    @(negedge clk);
    check("single_ack", 64'(ack), 64'h1);
    check("single_usedw", 64'(usedw), 64'd1);
    check("single_wr_early", 64'(owr), 64'd0);
    check("single_cnt", 64'(cnt), 64'd1);
    @(negedge clk);
    check("single_ack_off", 64'(ack), 64'd0);
    check("single_wr", 64'(owr), 64'd1);
    check("single_usedw_after", 64'(usedw), 64'd0);
    wait_drain("single");

    // Round-robin across four continuous requesters
    do_reset();
    mode = 1'b0;
    for (int n = 0; n < 6; n++)
      for (int ch = 0; ch < CH; ch++) begin
        load(ch, mk(ch, n));
        expect_out(ch, mk(ch, n));
      end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      check($sformatf("rr_ack_%0d", c), 64'(ack), 64'(1 << (c % 4)));
    end
    check("rr_cnt", 64'(cnt), 64'd24);
    wait_drain("rr");

    // Strict priority between ch1 and ch3
    do_reset();
    mode = 1'b1;
    for (int n = 0; n < 4; n++) begin
      load(1, mk(1, n));
      load(3, mk(3, n));
      expect_out(1, mk(1, n));
      expect_out(3, mk(3, n));
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("sp_ack_%0d", c), 64'(ack), (c % 2 == 0) ? 64'h2 : 64'h8);
    end
    wait_drain("sp");
    mode = 1'b0;

    // Backpressure: fill to depth, release, verify order and the held 9th request
    do_reset();
    ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      d = {48'(32'hB000 + n), 9'(n), 3'd1};
      load(0, d);
      expect_out(0, d);
    end
    repeat (24) @(negedge clk);
    check("bp_usedw_full", 64'(usedw), 64'd8);
    check("bp_cnt_full", 64'(cnt), 64'd8);
    check("bp_ack_held", 64'(ack), 64'd0);
    check("bp_wr_idle", 64'(owr), 64'd0);
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_stream_%0d", c), 64'(owr), 64'd1);
      if (c == 0) begin
        check("bp_no_capture_at_full", 64'(ack), 64'd0);
        check("bp_usedw_pop", 64'(usedw), 64'd7);
      end
      if (c == 1) begin
        check("bp_ninth_ack", 64'(ack), 64'h1);
        check("bp_usedw_same", 64'(usedw), 64'd7);
      end
    end
    @(negedge clk);
    check("bp_stream_end", 64'(owr), 64'd0);
    check("bp_cnt", 64'(cnt), 64'd10);
    wait_drain("bp");

    // Channel disable keeps request pending
    do_reset();
    en = 4'b1101;
    d = mk(1, 7);
    load(1, d);
    expect_out(1, d);
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack != 0) acks++;
    end
    check("dis_no_ack", 64'(acks), 64'd0);
    en = 4'hF;
    @(negedge clk);
    check("dis_reenable_ack", 64'(ack), 64'h2);
    wait_drain("dis");

    // Reset mid-operation with five buffered descriptors
    do_reset();
    ready = 1'b0;
    for (int n = 0; n < 5; n++) load(0, mk(0, n));
    i = 0;
    while (usedw != 5 && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("mid_fill_reached", 64'(i < 40), 64'd1);
    rst_n = 1'b0;
    clear_sources();
    @(negedge clk);
    check("mid_usedw", 64'(usedw), 64'd0);
    check("mid_wr", 64'(owr), 64'd0);
    check("mid_ack", 64'(ack), 64'd0);
    check("mid_cnt", 64'(cnt), 64'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_stay_empty", 64'(usedw), 64'd0);

    // Accept counter wrap with all channels requesting every cycle
    do_reset();
    raw_mode = 1'b1;
    i = 0;
    while (cnt != 16'hFFFF && i < 70000) begin
      @(negedge clk);
      i++;
    end
    check("wrap_reached", 64'(cnt), 64'hFFFF);
    @(negedge clk);
    check("wrap_zero", 64'(cnt), 64'd0);
    rst_n = 1'b0;
    raw_mode = 1'b0;
    clear_sources();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/network_descriptor_arbiter.md
# network_descriptor_arbiter

Parametrised N-channel descriptor multiplexer for the network transmit path. It replaces the fixed two-input (host/network) descriptor mux in front of the network input queue. Descriptor sources use a wr/ack handshake. The block arbitrates among them in round-robin or strict-priority mode, buffers granted descriptors in an internal FIFO, and drains them under downstream backpressure. It also reports fill level and an accepted-descriptor count.

## Interface

Parameters:
- CH_NUM, 4, number of descriptor source channels (2..8)
- CH_W, 2, channel index width; must equal clog2(CH_NUM), minimum 1
- TAG_W, 48, TSN tag width
- BUFID_W, 9, buffer id width
- TYPE_W, 3, packet type width
- FIFO_DEPTH, 8, internal descriptor FIFO depth; must be a power of 2, ≥2
- AW, 3, FIFO address width; must equal clog2(FIFO_DEPTH)

Ports:
- i_clk  in  1  system clock; all logic is in this one clock domain
- i_rst_n  in  1  reset, synchronous, active-low
- iv_tsntag  in  CH_NUM*TAG_W  per-channel TSN tag; channel k occupies bits [k*TAG_W +: TAG_W]
- iv_pkt_type  in  CH_NUM*TYPE_W  per-channel packet type
- iv_bufid  in  CH_NUM*BUFID_W  per-channel buffer id
- iv_descriptor_wr  in  CH_NUM  per-channel request; held high with stable data until ack
- ov_descriptor_ack  out  CH_NUM  per-channel one-cycle acceptance pulse
- iv_ch_enable  in  CH_NUM  per-channel grant enable
- i_arb_mode  in  1  0 = round-robin, 1 = strict priority (lowest index wins)
- ov_fifo_wdata  out  TAG_W+BUFID_W  output descriptor, packed as {tag, bufid}
- ov_pkt_type  out  TYPE_W  packet type of the output descriptor
- ov_src_ch  out  CH_W  source channel of the output descriptor
- o_fifo_wr  out  1  output valid pulse, one cycle per descriptor
- i_fifo_ready  in  1  downstream can accept a descriptor
- ov_fifo_usedw  out  AW+1  internal FIFO occupancy, 0..FIFO_DEPTH
- ov_accept_cnt  out  16  total accepted descriptors; wraps 0xFFFF→0

## Operation

- Eligibility of channel k in cycle t requires all of the following:
  - iv_descriptor_wr[k]=1
  - iv_ch_enable[k]=1
  - ov_descriptor_ack[k]=0 in cycle t (ack-cycle masking)
- Capture condition: at least one channel is eligible and usedw < FIFO_DEPTH, evaluated before any same-cycle pop. At full, capture is blocked even if a pop occurs in the same cycle.
- On capture at edge E:
  - Write {tag, bufid, type, channel} of the granted channel into the FIFO.
  - ov_descriptor_ack[grant] is 1 for the cycle after E only.
  - ov_accept_cnt increments by 1.
- Source rule: the wr value sampled during a channel's ack cycle is ignored. The source either drops wr or presents the next descriptor in that cycle.
- Round-robin: search starts at last_grant+1, modulo CH_NUM. last_grant resets to CH_NUM-1, so channel 0 has first priority after reset.
- Strict priority: the lowest eligible index wins.
- last_grant updates on every capture in both modes. A change of i_arb_mode takes effect from the next arbitration cycle.
- Clearing iv_ch_enable[k] while channel k is requesting leaves its request pending and un-acked. Re-enabling it makes the request eligible again.
- Output stage:
  - At an edge with usedw>0 and i_fifo_ready=1: pop the FIFO head into the output registers and set o_fifo_wr=1 for the next cycle.
  - Otherwise o_fifo_wr=0, and ov_fifo_wdata, ov_pkt_type and ov_src_ch hold their last values.
- usedw counts FIFO entries only and excludes the output register.
- Simultaneous capture and pop below full: usedw is unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation:
  - FIFO is emptied and buffered descriptors are discarded.
  - Pointers and last_grant are reinitialised.
  - Sources must re-drive their requests.

## Timing

- Reset values:
  - ov_descriptor_ack=0
  - o_fifo_wr=0
  - ov_fifo_wdata=0, ov_pkt_type=0, ov_src_ch=0
  - ov_fifo_usedw=0
  - ov_accept_cnt=0
  - last_grant=CH_NUM-1
- Every output is a register output.
- Latency:
  - request sampled at E0 → ack high in cycle E0..E1
  - earliest o_fifo_wr high in cycle E1..E2
  - minimum request-to-output latency: 2 cycles
- Throughput: one capture and one pop per cycle. A single channel sustains one descriptor every 2 cycles because of ack masking.

## Test plan

- **Single descriptor.** Reset, then ch0 presents tag=0x000000001234, bufid=0x05, type=3, with i_fifo_ready=1 → ack[0] pulses 1 cycle after sampling. o_fifo_wr pulses 1 cycle later with wdata={0x000000001234,0x05}, type=3, src=0. accept_cnt=1.
- **Round-robin.** mode=0, channels 0–3 request continuously, enable=4'hF → grant order 0,1,2,3,0,1…, one capture per cycle, each channel acked every 4th cycle.
- **Strict priority.** mode=1, ch1 and ch3 request continuously → grants alternate 1,3,1,3 because ch1 is masked in its ack cycle. Channels 0 and 2 never acked while idle.
- **Backpressure.** FIFO_DEPTH=8, i_fifo_ready=0, ch0 issues 10 descriptors with bufid 0..9 → 8 acks, usedw=8, 9th request held un-acked. Raise ready → 8 consecutive o_fifo_wr with bufid 0..7; 9th acked on the first cycle with usedw<8; final order 0..9, none lost.
- **Channel disable.** enable=4'b1101, ch1 requests → no ack for 20 cycles. Set enable=4'hF → ack[1] within 2 cycles.
- **Reset mid-operation and counter wrap.** With usedw=5, drive i_rst_n=0 for 1 cycle → usedw=0, o_fifo_wr=0, acks 0, accept_cnt=0. Separately, 65536 accepted descriptors → accept_cnt wraps to 0.
